lime_mem_arbiter: RTL and testbench

- Shares the processor's single-port unified memory between two requesters:
  - the multi-cycle CPU core (fetch via PC and load/store via ALUOut, after IorD select);
  - a DMA/program-loader port used to preload programs and move I/O data.
- Registered request/acknowledge handshake per port; arbitration is round-robin or CPU-priority with a starvation bound.
- Provides a stall output that freezes the CPU control FSM while its access is pending.

---
 rtl/lime_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_lime_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lime_mem_arbiter.sv
// Arbiter for the single-port unified memory, shared by the multi-cycle CPU and a DMA/loader port.
// Each access takes three cycles (grant, issue, capture); ties resolve round-robin or CPU-first with a DMA starvation bound.
//
// state   | meaning
// IDLE    | waiting for an eligible request; a grant latches the winner's access
// ISSUE   | mem_en high for this single cycle, memory samples at its closing edge
// CAPTURE | mem_rdata valid; owner's rdata loaded on reads, ack pulses next cycle
module lime_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CPU_PRIORITY = 0,
    parameter int MAX_WAIT     = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic       OWN_CPU    = 1'b0;
    localparam logic       OWN_DMA    = 1'b1;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       acc_we;
    logic [3:0] wait_cnt;
    logic       cpu_elig;
    logic       dma_elig;
    logic       grant_dma;

    // A port in its ack cycle is not eligible, so a held request is never granted twice.
    assign cpu_elig  = cpu_req && !cpu_ack;
    assign dma_elig  = dma_req && !dma_ack;
    assign cpu_stall = cpu_req && !cpu_ack;
    assign busy      = (state != IDLE);

    always_comb begin
        grant_dma = dma_elig;
        if (cpu_elig && dma_elig) begin
            if (CPU_PRIORITY == 0) begin
                grant_dma = (last_owner == OWN_CPU);
            end else begin
                grant_dma = (wait_cnt == WAIT_LIMIT);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            acc_we     <= 1'b0;
            wait_cnt   <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_elig || dma_elig) begin
                        owner     <= grant_dma;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_dma ? dma_we : cpu_we;
                        acc_we    <= grant_dma ? dma_we : cpu_we;
                        mem_addr  <= grant_dma ? dma_addr : cpu_addr;
                        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                        state     <= ISSUE;
                        if (grant_dma) begin
                            wait_cnt <= 4'd0;
                        end else if (dma_elig && wait_cnt != 4'hF) begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (!acc_we) begin
                        if (owner == OWN_DMA) begin
                            dma_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    cpu_ack    <= (owner == OWN_CPU);
                    dma_ack    <= (owner == OWN_DMA);
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lime_mem_arbiter.sv
// Bench for lime_mem_arbiter: a round-robin instance and a CPU-priority (MAX_WAIT=2) instance,
// each against its own memory and an access-level reference model.
module tb_lime_mem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [15:0] cpu_addr  [2];
    logic [15:0] cpu_wdata [2];
    logic        cpu_ack   [2];
    logic [15:0] cpu_rdata [2];
    logic        cpu_stall [2];
    logic        dma_req   [2];
    logic        dma_we    [2];
    logic [15:0] dma_addr  [2];
    logic [15:0] dma_wdata [2];
    logic        dma_ack   [2];
    logic [15:0] dma_rdata [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        busy      [2];

    always #5 CLK = ~CLK;

    lime_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_PRIORITY(0), .MAX_WAIT(4)) u_rr (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
        .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
        .dma_ack(dma_ack[0]), .dma_rdata(dma_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    lime_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_PRIORITY(1), .MAX_WAIT(2)) u_pr (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
        .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
        .dma_ack(dma_ack[1]), .dma_rdata(dma_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // memory behind each DUT
    logic [15:0] tmem [2][256];
    bit          t_pend [2];
    logic [15:0] t_val  [2];

    // reference model: the access currently granted, plus arbitration history
    logic [15:0] ref_mem [2][256];
    bit          g_valid [2];
    int          g_cyc   [2];
    bit          g_dma   [2];
    bit          g_we    [2];
    logic [15:0] g_addr  [2];
    logic [15:0] g_wdata [2];
    logic [15:0] g_rval  [2];
    bit          m_last  [2];
    int          m_wait  [2];
    logic [15:0] e_cpu_rd [2];
    logic [15:0] e_dma_rd [2];
    bit          exp_cack [2];
    bit          exp_dack [2];
    bit          c_act [2];
    bit          d_act [2];

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] cycle %0d: observed %0h expected %0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            g_valid[i]  = 1'b0;
            m_last[i]   = 1'b1;
            m_wait[i]   = 0;
            e_cpu_rd[i] = 16'h0;
            e_dma_rd[i] = 16'h0;
            exp_cack[i] = 1'b0;
            exp_dack[i] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("rst_mem_en", i, mem_en[i], 0);
            check("rst_mem_we", i, mem_we[i], 0);
            check("rst_mem_addr", i, mem_addr[i], 0);
            check("rst_mem_wdata", i, mem_wdata[i], 0);
            check("rst_cpu_ack", i, cpu_ack[i], 0);
            check("rst_dma_ack", i, dma_ack[i], 0);
            check("rst_cpu_rdata", i, cpu_rdata[i], 0);
            check("rst_dma_rdata", i, dma_rdata[i], 0);
            check("rst_busy", i, busy[i], 0);
            check("rst_cpu_stall", i, cpu_stall[i], cpu_req[i]);
        end
    endtask

    // Mid-cycle: serve memory, then compare every output against the model.
    task automatic observe();
        int d;
        bit e_en;
        bit e_busy;
        @(negedge CLK);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] = t_pend[i] ? t_val[i] : 16'($urandom);
            t_pend[i] = 1'b0;
            if (mem_en[i]) begin
                t_pend[i] = 1'b1;
                t_val[i]  = tmem[i][mem_addr[i][7:0]];
                if (mem_we[i]) tmem[i][mem_addr[i][7:0]] = mem_wdata[i];
            end
            d = g_valid[i] ? (cyc - g_cyc[i]) : 99;
            e_en        = (d == 1);
            e_busy      = (d == 1) || (d == 2);
            exp_cack[i] = (d == 3) && !g_dma[i];
            exp_dack[i] = (d == 3) && g_dma[i];
            if (d == 3 && !g_we[i]) begin
                if (g_dma[i]) e_dma_rd[i] = g_rval[i];
                else          e_cpu_rd[i] = g_rval[i];
            end
            check("mem_en", i, mem_en[i], e_en);
            check("mem_we", i, mem_we[i], e_en && g_we[i]);
            check("busy", i, busy[i], e_busy);
            check("cpu_ack", i, cpu_ack[i], exp_cack[i]);
            check("dma_ack", i, dma_ack[i], exp_dack[i]);
            check("cpu_rdata", i, cpu_rdata[i], e_cpu_rd[i]);
            check("dma_rdata", i, dma_rdata[i], e_dma_rd[i]);
            check("ack_exclusive", i, cpu_ack[i] && dma_ack[i], 0);
            if (e_en) begin
                check("mem_addr", i, mem_addr[i], g_addr[i]);
                if (g_we[i]) check("mem_wdata", i, mem_wdata[i], g_wdata[i]);
            end
        end
    endtask

    // After inputs are set: check stall, then let the model decide this cycle's grant.
    task automatic commit();
        bit ce;
        bit de;
        bit pick_dma;
        logic [7:0] a;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("cpu_stall", i, cpu_stall[i], cpu_req[i] && !exp_cack[i]);
            if (!Reset && (!g_valid[i] || (cyc - g_cyc[i]) >= 3)) begin
                ce = cpu_req[i] && !exp_cack[i];
                de = dma_req[i] && !exp_dack[i];
                if (ce || de) begin
                    pick_dma = de;
                    if (ce && de) begin
                        if (i == 0) begin
                            pick_dma = !m_last[i];
                        end else begin
                            pick_dma = (m_wait[i] == 2);
                            if (!pick_dma && m_wait[i] < 15) m_wait[i]++;
                        end
                    end
                    if (pick_dma) m_wait[i] = 0;
                    m_last[i]  = pick_dma;
                    g_valid[i] = 1'b1;
                    g_cyc[i]   = cyc;
                    g_dma[i]   = pick_dma;
                    g_we[i]    = pick_dma ? dma_we[i] : cpu_we[i];
                    g_addr[i]  = pick_dma ? dma_addr[i] : cpu_addr[i];
                    g_wdata[i] = pick_dma ? dma_wdata[i] : cpu_wdata[i];
                    a = g_addr[i][7:0];
                    if (g_we[i]) ref_mem[i][a] = g_wdata[i];
                    else         g_rval[i] = ref_mem[i][a];
                end
            end
        end
    endtask

    task automatic step();
        observe();
        commit();
    endtask

    task automatic rand_drive(input int i);
        if (cpu_ack[i]) begin
            c_act[i]   = 1'b0;
            cpu_req[i] = 1'($urandom_range(0, 1));
        end else if (!c_act[i]) begin
            if ($urandom_range(0, 4) < 2) begin
                c_act[i]     = 1'b1;
                cpu_req[i]   = 1'b1;
                cpu_we[i]    = 1'($urandom_range(0, 1));
                cpu_addr[i]  = 16'($urandom_range(0, 15));
                cpu_wdata[i] = 16'($urandom);
            end else begin
                cpu_req[i] = 1'b0;
            end
        end
        if (dma_ack[i]) begin
            d_act[i]   = 1'b0;
            dma_req[i] = 1'($urandom_range(0, 1));
        end else if (!d_act[i]) begin
            if ($urandom_range(0, 4) < 2) begin
                d_act[i]     = 1'b1;
                dma_req[i]   = 1'b1;
                dma_we[i]    = 1'($urandom_range(0, 1));
                dma_addr[i]  = 16'($urandom_range(0, 15));
                dma_wdata[i] = 16'($urandom);
            end else begin
                dma_req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
            dma_req[i] = 0; dma_we[i] = 0; dma_addr[i] = 0; dma_wdata[i] = 0;
            mem_rdata[i] = 0; t_pend[i] = 0; t_val[i] = 0; c_act[i] = 0; d_act[i] = 0;
            for (int j = 0; j < 256; j++) begin
                tmem[i][j]    = (16'(j) * 16'h0101) ^ 16'hA5C3;
                ref_mem[i][j] = (16'(j) * 16'h0101) ^ 16'hA5C3;
            end
            tmem[i][8'h10]    = 16'hBEEF;
            ref_mem[i][8'h10] = 16'hBEEF;
        end
        model_reset();

        // reset state, stall follows cpu_req while in reset
        #1;
        check_reset_outputs();
        for (int i = 0; i < 2; i++) cpu_req[i] = 1'b1;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 2; i++) cpu_req[i] = 1'b0;
        step();
        observe();
        Reset = 1'b0;
        commit();
        step();

        // CPU read alone
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 16'h0010;
        end
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("rd_mem_en_c1", i, mem_en[i], 1);
            check("rd_mem_addr_c1", i, mem_addr[i], 16'h0010);
            check("rd_mem_we_c1", i, mem_we[i], 0);
            check("rd_stall_c1", i, cpu_stall[i], 1);
        end
        commit();
        step();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("rd_cpu_ack_c3", i, cpu_ack[i], 1);
            check("rd_cpu_rdata_c3", i, cpu_rdata[i], 16'hBEEF);
            cpu_req[i] = 0;
        end
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("rd_cpu_ack_c4", i, cpu_ack[i], 0);
            check("rd_cpu_rdata_held", i, cpu_rdata[i], 16'hBEEF);
        end
        commit();

        // DMA write alone
        observe();
        for (int i = 0; i < 2; i++) begin
            dma_req[i] = 1; dma_we[i] = 1; dma_addr[i] = 16'h0200; dma_wdata[i] = 16'h1234;
        end
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("wr_mem_en_c1", i, mem_en[i], 1);
            check("wr_mem_we_c1", i, mem_we[i], 1);
            check("wr_mem_addr_c1", i, mem_addr[i], 16'h0200);
            check("wr_mem_wdata_c1", i, mem_wdata[i], 16'h1234);
        end
        commit();
        step();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("wr_dma_ack_c3", i, dma_ack[i], 1);
            check("wr_dma_rdata", i, dma_rdata[i], 0);
            dma_req[i] = 0;
        end
        commit();
        step();

        // both ports requesting continuously: round-robin CPU, DMA, CPU, DMA
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 16'h0003;
            dma_req[i] = 1; dma_we[i] = 0; dma_addr[i] = 16'h0005;
        end
        commit();
        for (int k = 1; k <= 12; k++) begin
            observe();
            check("rr_cpu_ack", 0, cpu_ack[0], (k == 3) || (k == 9));
            check("rr_dma_ack", 0, dma_ack[0], (k == 6) || (k == 12));
            commit();
        end
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; dma_req[i] = 0;
        end
        commit();
        repeat (4) step();

        // repeated ties with DMA withdrawing on loss: starvation bound forces DMA on the third tie
        for (int r = 0; r < 4; r++) begin
            observe();
            for (int i = 0; i < 2; i++) begin
                cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 16'h0001;
                dma_req[i] = 1; dma_we[i] = 0; dma_addr[i] = 16'h0002;
            end
            commit();
            step();
            step();
            observe();
            check("starve_cpu_ack", 1, cpu_ack[1], r != 2);
            check("starve_dma_ack", 1, dma_ack[1], r == 2);
            for (int i = 0; i < 2; i++) begin
                cpu_req[i] = 0; dma_req[i] = 0;
            end
            commit();
            step();
        end

        // reset pulse during ISSUE of a CPU read
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 16'h0010;
        end
        commit();
        observe();
        for (int i = 0; i < 2; i++) check("rst_issue_mem_en", i, mem_en[i], 1);
        Reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        commit();
        observe();
        Reset = 1'b0;
        commit();
        observe();
        for (int i = 0; i < 2; i++) check("regrant_mem_en_c1", i, mem_en[i], 1);
        commit();
        observe();
        for (int i = 0; i < 2; i++) check("regrant_cpu_ack_c2", i, cpu_ack[i], 0);
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("regrant_cpu_ack_c3", i, cpu_ack[i], 1);
            check("regrant_cpu_rdata", i, cpu_rdata[i], 16'hBEEF);
            cpu_req[i] = 0;
        end
        commit();
        step();

        // request held through the ack cycle is not granted again
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 16'h0007;
        end
        commit();
        step();
        step();
        observe();
        for (int i = 0; i < 2; i++) check("hold_cpu_ack_c3", i, cpu_ack[i], 1);
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("hold_busy_c4", i, busy[i], 0);
            check("hold_mem_en_c4", i, mem_en[i], 0);
            cpu_req[i] = 0;
        end
        commit();
        observe();
        for (int i = 0; i < 2; i++) begin
            check("hold_busy_c5", i, busy[i], 0);
            check("hold_mem_en_c5", i, mem_en[i], 0);
        end
        commit();

        // randomized traffic on both instances
        repeat (1500) begin
            observe();
            for (int i = 0; i < 2; i++) rand_drive(i);
            commit();
        end
        observe();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; dma_req[i] = 0;
        end
        commit();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
